debounce_multi: RTL

Parameterised multi-channel debouncer for push-buttons and switches feeding the UART receiver test harness and board-level control logic. Each channel independently filters a noisy asynchronous input into a clean level, with separate press (rising) and release (falling) hold times. Per-channel one-cycle rise and fall pulses are also produced, so downstream logic needs no edge detectors of its own.

---
 rtl/debounce_multi_if.sv | 13 +
 rtl/debounce_multi.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/debounce_multi_if.sv
// Channel bundle for debounce_multi: raw inputs in, filtered levels and edge pulses out.
interface debounce_multi_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] noisy_in;
    logic [CHANNELS-1:0] debounced;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic                any_change;

    modport master (output noisy_in, input debounced, rise, fall, any_change);
    modport slave  (input noisy_in, output debounced, rise, fall, any_change);
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel debouncer with independent press/release hold times and registered edge pulses.
// Define DEBOUNCE_SYNC_EN to insert a 2-flop synchroniser per channel ahead of each FSM.
module debounce_lane #(
    parameter int PRESS_CYCLES   = 50000,
    parameter int RELEASE_CYCLES = 50000,
    parameter int COUNT_WIDTH    = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic debounced,
    output logic rise,
    output logic fall,
    output logic pulse_nxt
);
    typedef enum logic [1:0] {STABLE_LO, ARM_HI, STABLE_HI, ARM_LO} state_t;

    localparam logic [COUNT_WIDTH-1:0] HI_TERM = COUNT_WIDTH'(PRESS_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] LO_TERM = COUNT_WIDTH'(RELEASE_CYCLES - 1);

    state_t                 state;
    logic [COUNT_WIDTH-1:0] cnt;
    logic                   s;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (reset) sync <= 2'b00;
        else       sync <= {sync[0], din};
    end

    assign s = sync[1];
`else
    assign s = din;
`endif

    // Mirrors the FSM's pulse decision so the top can register any_change in the same cycle.
    assign pulse_nxt = !reset &&
                       ((state == ARM_HI &&  s && cnt == HI_TERM) ||
                        (state == ARM_LO && !s && cnt == LO_TERM));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= STABLE_LO;
            cnt       <= '0;
            debounced <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE_LO: begin
                    cnt       <= '0;
                    debounced <= 1'b0;
                    if (s) state <= ARM_HI;
                end
                ARM_HI: begin
                    if (!s) begin
                        state <= STABLE_LO;
                        cnt   <= '0;
                    end else if (cnt == HI_TERM) begin
                        state     <= STABLE_HI;
                        cnt       <= '0;
                        debounced <= 1'b1;
                        rise      <= 1'b1;
                    end else begin
                        cnt <= cnt + COUNT_WIDTH'(1);
                    end
                end
                STABLE_HI: begin
                    cnt       <= '0;
                    debounced <= 1'b1;
                    if (!s) state <= ARM_LO;
                end
                ARM_LO: begin
                    if (s) begin
                        state <= STABLE_HI;
                        cnt   <= '0;
                    end else if (cnt == LO_TERM) begin
                        state     <= STABLE_LO;
                        cnt       <= '0;
                        debounced <= 1'b0;
                        fall      <= 1'b1;
                    end else begin
                        cnt <= cnt + COUNT_WIDTH'(1);
                    end
                end
                default: begin
                    state     <= STABLE_LO;
                    cnt       <= '0;
                    debounced <= 1'b0;
                end
            endcase
        end
    end
endmodule

module debounce_multi #(
    parameter int CHANNELS       = 4,
    parameter int PRESS_CYCLES   = 50000,
    parameter int RELEASE_CYCLES = 50000,
    parameter int COUNT_WIDTH    = 19
) (
    input  logic              clk,
    input  logic              reset,
    debounce_multi_if.slave   bus
);
    logic [CHANNELS-1:0] deb;
    logic [CHANNELS-1:0] rs;
    logic [CHANNELS-1:0] fl;
    logic [CHANNELS-1:0] pn;
    logic                any_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        debounce_lane #(
            .PRESS_CYCLES   (PRESS_CYCLES),
            .RELEASE_CYCLES (RELEASE_CYCLES),
            .COUNT_WIDTH    (COUNT_WIDTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .din       (bus.noisy_in[i]),
            .debounced (deb[i]),
            .rise      (rs[i]),
            .fall      (fl[i]),
            .pulse_nxt (pn[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) any_q <= 1'b0;
        else       any_q <= |pn;
    end

    assign bus.debounced  = deb;
    assign bus.rise       = rs;
    assign bus.fall       = fl;
    assign bus.any_change = any_q;
endmodule
